// File: rtl/glyph_loader_pkg.sv
// Font geometry and loader state encoding, shared by the glyph loader and the text renderer.
// The renderer finds a glyph's first RAM row with glyph_base(letter) = letter*HEIGHT.
package glyph_loader_pkg;

   localparam int GLYPHS = 26;
   localparam int HEIGHT = 17;
   localparam int WIDTH  = 15;
   localparam int ADDR_W = 9;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HI    = 3'd1,
      ST_LO    = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   function automatic logic [ADDR_W-1:0] glyph_base(input logic [4:0] letter);
      return ADDR_W'(32'(letter) * HEIGHT);
   endfunction

endpackage

// File: rtl/glyph_loader.sv
// Loads A..Z glyph rows from a byte stream (HI then LO byte per row) into the external font RAM.
// wr_en fires the cycle after the LO byte is accepted; byte_ready is the only backpressure, gaps wait indefinitely.
module glyph_loader #(
   parameter int GLYPHS = glyph_loader_pkg::GLYPHS,
   parameter int HEIGHT = glyph_loader_pkg::HEIGHT,
   parameter int WIDTH  = glyph_loader_pkg::WIDTH
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 start,
   input  logic                                 abort,
   input  logic                                 byte_valid,
   input  logic [7:0]                           byte_data,
   output logic                                 byte_ready,
   output logic                                 wr_en,
   output logic [glyph_loader_pkg::ADDR_W-1:0]  wr_addr,
   output logic [WIDTH-1:0]                     wr_data,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err
);
   import glyph_loader_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GLYPHS * HEIGHT - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [WIDTH-1:0]  row_q;
   logic              err_q;
   logic              accept;

   // Abort masks byte_ready so a byte offered in the abort cycle is never consumed.
   assign byte_ready = ((state_q == ST_HI) || (state_q == ST_LO)) && !abort;
   assign accept     = byte_ready && byte_valid;
   assign wr_en      = (state_q == ST_WRITE) && !abort;
   assign wr_addr    = addr_q;
   assign wr_data    = row_q;
   assign busy       = (state_q == ST_HI) || (state_q == ST_LO) || (state_q == ST_WRITE);
   assign done       = (state_q == ST_DONE);
   assign err        = err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_ERR: if (start)  state_d = ST_HI;
            ST_HI:           if (accept) state_d = byte_data[7] ? ST_ERR : ST_LO;
            ST_LO:           if (accept) state_d = ST_WRITE;
            ST_WRITE:        state_d = (addr_q == LAST_ADDR) ? ST_DONE : ST_HI;
            ST_DONE:         state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
         endcase
      end
   end

   // Address advances by one per row written, so glyph bases land on letter*HEIGHT without a multiplier.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= '0;
         row_q  <= '0;
         err_q  <= 1'b0;
      end else if (!abort) begin
         case (state_q)
            ST_IDLE, ST_ERR: begin
               if (start) begin
                  addr_q <= '0;
                  err_q  <= 1'b0;
               end
            end
            ST_HI: begin
               if (accept) begin
                  if (byte_data[7]) err_q <= 1'b1;
                  else              row_q[14:8] <= byte_data[6:0];
               end
            end
            ST_LO: begin
               if (accept) row_q[7:0] <= byte_data;
            end
            ST_WRITE: addr_q <= addr_q + 9'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/glyph_loader.md
GLYPH_LOADER -- requirements
Module: glyph_loader

Interface
REQ-001 SHALL have parameter GLYPHS, default 26, meaning number of glyphs loaded (A..Z).
REQ-002 SHALL have parameter HEIGHT, default 17, meaning rows per glyph.
REQ-003 SHALL have parameter WIDTH, default 15, meaning bits per glyph row.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1 bit, meaning reset; it is asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit, meaning a one-cycle request to begin a full font load.
REQ-007 SHALL have port abort, input, 1 bit, meaning cancel the current load.
REQ-008 SHALL have port byte_valid, input, 1 bit, meaning byte_data is valid.
REQ-009 SHALL have port byte_data, input, 8 bits, meaning a serial font stream byte.
REQ-010 SHALL have port byte_ready, output, 1 bit, meaning the loader accepts a byte this cycle.
REQ-011 SHALL have port wr_en, output, 1 bit, meaning the font RAM write strobe.
REQ-012 SHALL have port wr_addr, output, 9 bits, meaning the font RAM row address, equal to letter*HEIGHT+row.
REQ-013 SHALL have port wr_data, output, WIDTH bits, meaning the glyph row bitmap with the MSB as the leftmost pixel.
REQ-014 SHALL have port busy, output, 1 bit, meaning a load is in progress.
REQ-015 SHALL have port done, output, 1 bit, meaning a one-cycle pulse on successful completion.
REQ-016 SHALL have port err, output, 1 bit, meaning a sticky format error.

Function
REQ-017 SHALL implement the states IDLE, HI, LO, WRITE, DONE and ERR.
REQ-018 SHALL, in IDLE, go to HI on start=1, clear err, and clear the address counter.
REQ-019 SHALL drive byte_ready=1 only in HI and LO; a byte is accepted when byte_valid and byte_ready are both 1.
REQ-020 SHALL, in HI, on an accepted byte, capture byte_data[6:0] as row bits [14:8] and go to LO.
REQ-021 SHALL, in HI, go to ERR instead if byte_data[7]=1.
REQ-022 SHALL, in LO, on an accepted byte, capture byte_data as row bits [7:0] and go to WRITE.
REQ-023 SHALL, in WRITE, assert wr_en for exactly one cycle with stable wr_addr and wr_data.
REQ-024 SHALL, after WRITE, increment the address; the next state is HI, or DONE if the address written was GLYPHS*HEIGHT-1 (441).
REQ-025 SHALL form addresses by incrementing a counter, with no multiplier; the address SHALL run 0..441 contiguously with no gaps.
REQ-026 SHALL, in DONE, pulse done for one cycle, then go to IDLE.
REQ-027 SHALL, in ERR, hold err=1, keep byte_ready=0, and make no writes; start returns it to HI with err cleared.
REQ-028 SHALL drive busy=1 in HI, LO and WRITE, and busy=0 otherwise.
REQ-029 SHALL ignore start while busy=1.
REQ-030 SHALL, on abort=1 in any state, go to IDLE next cycle with no write and no done pulse; abort has priority over start and over byte acceptance in the same cycle.
REQ-031 SHALL have zero wr_en cycles outside WRITE.
REQ-032 SHALL make the byte-to-write latency 1 cycle: wr_en is high in the cycle after the LO byte is accepted.
REQ-033 SHALL allow byte_valid gaps of any length with no timeout; state is held while waiting.
REQ-034 SHALL achieve a minimum full load of 442 rows x 3 cycles = 1326 cycles after start.

Reset
REQ-035 SHALL, while reset_n=0, asynchronously force state=IDLE, address=0, row register=0, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0 and err=0.
REQ-036 SHALL, on reset_n asserted mid-load, leave no further writes; the RAM contents are then undefined and a new start is required.
REQ-037 SHALL act on its first start no earlier than the first clk edge after reset_n deasserts.

Structure
REQ-038 SHALL place GLYPHS, HEIGHT, WIDTH, the address width (9) and the state encoding in a shared font package, also used by the text renderer for glyph base addresses (letter*17).
REQ-039 SHALL be a single module with no sub-module; the font RAM is external, and the write port drives the same 17-row-per-glyph layout the renderer reads.

Verification
REQ-040 SHALL verify a full load: start, then 884 bytes of an incrementing pattern with byte_valid held -> 442 wr_en pulses, addr 0..441 in order, done at cycle 1327, busy low afterwards.
REQ-041 SHALL verify a single-row check: bytes 0x7F,0xFF for row 0 -> wr_addr=0, wr_data=0x7FFF; bytes 0x40,0x01 at address 289 (R row 0) -> wr_data=0x4001.
REQ-042 SHALL verify a format error: the first HI byte is 0x80 -> err=1, byte_ready=0, no wr_en; a following start clears err and the load restarts at addr 0.
REQ-043 SHALL verify abort: abort after 100 rows together with byte_valid=1 -> no write in that cycle, state IDLE, no done pulse; a new start writes addr 0 first.
REQ-044 SHALL verify backpressure and gaps: byte_valid randomly low 50% -> same 442 writes and the same data as the gap-free run.
REQ-045 SHALL verify reset mid-load: reset_n low during WRITE -> wr_en=0 immediately, all outputs zero; after release, start reloads from addr 0.
